swipt_sequencer: RTL and testbench
==================================

# swipt_sequencer

Parametrised top-level program sequencer for the SWIPT transmitter. It steps the link through frequency optimisation, a fixed mean-current measurement window and the data/power phase, and drives the `freq` and duty (`l`) words consumed by the SWIPT output stage. Over the fixed-sequence controller it adds:

- periodic and on-demand re-optimisation;
- a frequency-search timeout with fallback;
- range-checked comms override;
- explicit start/done strobes toward the sub-blocks.

## Interface
Parameters:
- FREQ_W, 20, frequency word width
- DUTY_W, 12, duty word width
- START_FREQ, 35000, default/fallback frequency
- START_DUTY, 200, default duty
- FREQ_MIN, 20000, lowest accepted comms frequency (inclusive)
- FREQ_MAX, 100000, highest accepted comms frequency (inclusive)
- MEAS_CYCLES, 1000000, measurement window length in cycles (≥1)
- OPT_TIMEOUT, 4000000, max cycles spent in FREQ_OPT (≥2)
- REOPT_CYCLES, 0, cycles in DATA before automatic re-optimisation (0 = disabled)
- CNT_W, 32, internal counter width; must hold max(MEAS_CYCLES, OPT_TIMEOUT, REOPT_CYCLES)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- swipt_alive  in  1  heartbeat-derived enable
- comms_ctrl  in  1  level: comms owns freq/duty
- comms_valid  in  1  strobe: comms_freq/comms_duty valid this cycle
- comms_freq  in  FREQ_W  requested frequency
- comms_duty  in  DUTY_W  requested duty
- reopt_req  in  1  strobe: request re-optimisation
- freq_alg_done  in  1  frequency search finished
- new_freq  in  FREQ_W  search candidate
- best_freq  in  FREQ_W  search result
- data_meas_req  in  1  measurement request from data block
- freq  out  FREQ_W  frequency word to output stage
- duty  out  DUTY_W  duty word to output stage
- phase  out  3  current state encoding
- freq_start  out  1  one-cycle pulse on FREQ_OPT entry
- measure  out  1  mean-current accumulate enable
- meas_done  out  1  one-cycle pulse at end of measurement window
- opt_timeout  out  1  sticky: last search timed out
- comms_err  out  1  one-cycle pulse: out-of-range comms_freq rejected

## Operation
State encodings: IDLE=0, FREQ_OPT=1, MEASURE=2, DATA=3, COMMS=4.

Priority per cycle: rst > ~swipt_alive > comms_ctrl > state logic.

Reset (rst=1):
- State goes to IDLE.
- freq=START_FREQ, duty=START_DUTY.
- All strobes, measure and opt_timeout = 0.
- Counters cleared.

~swipt_alive: same as reset, except opt_timeout holds its value.

comms_ctrl=1:
- Enters/stays in COMMS; measure=0.
- On comms_valid with FREQ_MIN ≤ comms_freq ≤ FREQ_MAX: load freq←comms_freq, duty←comms_duty.
- On comms_valid with comms_freq out of range: freq and duty unchanged, comms_err pulses.
- On comms_ctrl falling: go to IDLE; freq/duty keep the last comms values.

States:
- IDLE: next cycle goes to FREQ_OPT; freq_start=1 in that transition cycle. Counter cleared.
- FREQ_OPT:
  - While ~freq_alg_done: freq←new_freq each cycle; counter increments.
  - When freq_alg_done: freq←best_freq, clear opt_timeout, go to MEASURE.
  - When the counter reaches OPT_TIMEOUT−1 without done: freq←START_FREQ, set opt_timeout, go to MEASURE.
  - If done and timeout coincide, done wins.
- MEASURE:
  - measure=1 for exactly MEAS_CYCLES cycles.
  - The last-cycle transition pulses meas_done and goes to DATA; measure=0 from the first DATA cycle.
- DATA:
  - measure←data_meas_req, registered with 1-cycle delay.
  - Re-opt counter increments.
  - reopt_req, or counter = REOPT_CYCLES−1 with REOPT_CYCLES≠0: go to FREQ_OPT, pulse freq_start, clear counters, force measure=0.
- reopt_req is ignored outside DATA.
- duty is written only in reset, in the ~swipt_alive case, and in COMMS.

Counters saturate and never wrap. All outputs are registered.

## Timing
- phase, freq, duty, measure and all strobes update on the clk edge after the causing input; no combinational paths from input to output.
- FREQ_OPT tracking: new_freq sampled at edge N appears on freq after edge N.
- Measurement window: meas_done is asserted in the cycle after the last measure=1 cycle; total MEASURE dwell = MEAS_CYCLES cycles.
- rst or swipt_alive deassertion mid-MEASURE: measure drops the next edge, and meas_done is not emitted.
- comms_ctrl rising mid-FREQ_OPT: search is abandoned, no timeout flag; freq_start is re-pulsed only on the next IDLE→FREQ_OPT transition.

## Test plan
Bench parameters: MEAS_CYCLES=8, OPT_TIMEOUT=16, REOPT_CYCLES=0.
- Reset:
  - Stimulus: rst high 3 cycles, then low with swipt_alive=1.
  - Response: freq=35000, duty=200; phase 0→1 with one freq_start pulse.
- Normal sequence:
  - Stimulus: new_freq ramps 30000,30100,…; freq_alg_done asserted on the 5th cycle with best_freq=30200.
  - Response: freq follows with 1-cycle lag, then 30200; measure high exactly 8 cycles; one meas_done pulse; phase=3.
- Timeout:
  - Stimulus: freq_alg_done held low.
  - Response: after 16 cycles in FREQ_OPT, freq=35000, opt_timeout=1, phase=2. A later successful search clears opt_timeout.
- Comms:
  - Stimulus: in DATA, comms_ctrl=1; comms_valid with 50000/300, then 150000/100.
  - Response: freq=50000, duty=300, phase=4; second write rejected with a comms_err pulse and values unchanged. Dropping comms_ctrl gives phase 0→1.
- Re-optimisation:
  - Stimulus: reopt_req in DATA; separately, a run with REOPT_CYCLES=20.
  - Response: freq_start pulse and phase=1 on the next cycle; with REOPT_CYCLES=20, return to FREQ_OPT after 20 DATA cycles.
- Heartbeat loss:
  - Stimulus: swipt_alive low on the 4th MEASURE cycle.
  - Response: measure=0 next cycle, no meas_done, freq=35000, phase=0; opt_timeout keeps its value.

Source files
------------

// File: rtl/swipt_sequencer.sv
// Program sequencer for the SWIPT transmitter: frequency search, mean-current
// measurement window, data/power phase and comms override of the freq/duty words.
module swipt_sequencer #(
    parameter int unsigned FREQ_W       = 20,
    parameter int unsigned DUTY_W       = 12,
    parameter int unsigned START_FREQ   = 35000,
    parameter int unsigned START_DUTY   = 200,
    parameter int unsigned FREQ_MIN     = 20000,
    parameter int unsigned FREQ_MAX     = 100000,
    parameter int unsigned MEAS_CYCLES  = 1000000,
    parameter int unsigned OPT_TIMEOUT  = 4000000,
    parameter int unsigned REOPT_CYCLES = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swipt_alive,
    input  logic              comms_ctrl,
    input  logic              comms_valid,
    input  logic [FREQ_W-1:0] comms_freq,
    input  logic [DUTY_W-1:0] comms_duty,
    input  logic              reopt_req,
    input  logic              freq_alg_done,
    input  logic [FREQ_W-1:0] new_freq,
    input  logic [FREQ_W-1:0] best_freq,
    input  logic              data_meas_req,
    output logic [FREQ_W-1:0] freq,
    output logic [DUTY_W-1:0] duty,
    output logic [2:0]        phase,
    output logic              freq_start,
    output logic              measure,
    output logic              meas_done,
    output logic              opt_timeout,
    output logic              comms_err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FREQ_OPT = 3'd1,
        MEASURE  = 3'd2,
        DATA     = 3'd3,
        COMMS    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  OPT_LAST   = CNT_W'(OPT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  MEAS_LAST  = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REOPT_LAST = CNT_W'((REOPT_CYCLES == 0) ? 0 : REOPT_CYCLES - 1);
    localparam logic [FREQ_W-1:0] FREQ_LO    = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] FREQ_HI    = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] FREQ_DEF   = FREQ_W'(START_FREQ);
    localparam logic [DUTY_W-1:0] DUTY_DEF   = DUTY_W'(START_DUTY);

    state_t            state_q;
    logic [FREQ_W-1:0] freq_q;
    logic [DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              freq_start_q;
    logic              measure_q;
    logic              meas_done_q;
    logic              opt_timeout_q;
    logic              comms_err_q;
    logic              comms_ok;
    logic              reopt_now;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign comms_ok  = (comms_freq >= FREQ_LO) && (comms_freq <= FREQ_HI);
    assign reopt_now = reopt_req || ((REOPT_CYCLES != 0) && (cnt_q == REOPT_LAST));

    always_ff @(posedge clk) begin
        if (rst || !swipt_alive) begin
            state_q      <= IDLE;
            freq_q       <= FREQ_DEF;
            duty_q       <= DUTY_DEF;
            cnt_q        <= '0;
            freq_start_q <= 1'b0;
            measure_q    <= 1'b0;
            meas_done_q  <= 1'b0;
            comms_err_q  <= 1'b0;
            if (rst) begin
                opt_timeout_q <= 1'b0;
            end
        end else begin
            freq_start_q <= 1'b0;
            meas_done_q  <= 1'b0;
            comms_err_q  <= 1'b0;
            if (comms_ctrl) begin
                state_q   <= COMMS;
                measure_q <= 1'b0;
                cnt_q     <= '0;
                if (comms_valid) begin
                    if (comms_ok) begin
                        freq_q <= comms_freq;
                        duty_q <= comms_duty;
                    end else begin
                        comms_err_q <= 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q      <= FREQ_OPT;
                        freq_start_q <= 1'b1;
                        cnt_q        <= '0;
                    end
                    FREQ_OPT: begin
                        // A completed search takes precedence over a coincident timeout.
                        if (freq_alg_done) begin
                            freq_q        <= best_freq;
                            opt_timeout_q <= 1'b0;
                            state_q       <= MEASURE;
                            measure_q     <= 1'b1;
                            cnt_q         <= '0;
                        end else if (cnt_q == OPT_LAST) begin
                            freq_q        <= FREQ_DEF;
                            opt_timeout_q <= 1'b1;
                            state_q       <= MEASURE;
                            measure_q     <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            freq_q <= new_freq;
                            cnt_q  <= cnt_d;
                        end
                    end
                    MEASURE: begin
                        if (cnt_q == MEAS_LAST) begin
                            state_q     <= DATA;
                            measure_q   <= 1'b0;
                            meas_done_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    DATA: begin
                        if (reopt_now) begin
                            state_q      <= FREQ_OPT;
                            freq_start_q <= 1'b1;
                            measure_q    <= 1'b0;
                            cnt_q        <= '0;
                        end else begin
                            measure_q <= data_meas_req;
                            cnt_q     <= cnt_d;
                        end
                    end
                    COMMS: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign freq        = freq_q;
    assign duty        = duty_q;
    assign phase       = state_q;
    assign freq_start  = freq_start_q;
    assign measure     = measure_q;
    assign meas_done   = meas_done_q;
    assign opt_timeout = opt_timeout_q;
    assign comms_err   = comms_err_q;

endmodule

// File: tb/tb_swipt_sequencer.sv
// Directed bench for swipt_sequencer: reset, search, timeout, heartbeat loss,
// comms override and re-optimisation, with hand-computed expectations.
module tb_swipt_sequencer;

    logic        clk = 1'b0;
    logic        rst, swipt_alive, swipt_alive2;
    logic        comms_ctrl, comms_valid, reopt_req, freq_alg_done, data_meas_req;
    logic [19:0] comms_freq, new_freq, best_freq;
    logic [11:0] comms_duty;

    logic [19:0] freq, freq2;
    logic [11:0] duty, duty2;
    logic [2:0]  phase, phase2;
    logic        freq_start, measure, meas_done, opt_timeout, comms_err;
    logic        freq_start2, measure2, meas_done2, opt_timeout2, comms_err2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    swipt_sequencer #(.MEAS_CYCLES(8), .OPT_TIMEOUT(16), .REOPT_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .swipt_alive(swipt_alive), .comms_ctrl(comms_ctrl),
        .comms_valid(comms_valid), .comms_freq(comms_freq), .comms_duty(comms_duty),
        .reopt_req(reopt_req), .freq_alg_done(freq_alg_done), .new_freq(new_freq),
        .best_freq(best_freq), .data_meas_req(data_meas_req),
        .freq(freq), .duty(duty), .phase(phase), .freq_start(freq_start),
        .measure(measure), .meas_done(meas_done), .opt_timeout(opt_timeout),
        .comms_err(comms_err)
    );

    swipt_sequencer #(.MEAS_CYCLES(8), .OPT_TIMEOUT(16), .REOPT_CYCLES(20)) dut2 (
        .clk(clk), .rst(rst), .swipt_alive(swipt_alive2), .comms_ctrl(comms_ctrl),
        .comms_valid(comms_valid), .comms_freq(comms_freq), .comms_duty(comms_duty),
        .reopt_req(reopt_req), .freq_alg_done(freq_alg_done), .new_freq(new_freq),
        .best_freq(best_freq), .data_meas_req(data_meas_req),
        .freq(freq2), .duty(duty2), .phase(phase2), .freq_start(freq_start2),
        .measure(measure2), .meas_done(meas_done2), .opt_timeout(opt_timeout2),
        .comms_err(comms_err2)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; swipt_alive = 1'b0; swipt_alive2 = 1'b0;
        comms_ctrl = 1'b0; comms_valid = 1'b0; comms_freq = '0; comms_duty = '0;
        reopt_req = 1'b0; freq_alg_done = 1'b0; new_freq = '0; best_freq = '0;
        data_meas_req = 1'b0;

        // Reset
        tick(3);
        chk("rst_freq", freq, 35000);
        chk("rst_duty", duty, 200);
        chk("rst_phase", phase, 0);
        chk("rst_fstart", freq_start, 0);
        chk("rst_measure", measure, 0);
        chk("rst_timeout", opt_timeout, 0);
        rst = 1'b0; swipt_alive = 1'b1; new_freq = 20'd30000;
        tick();
        chk("start_phase", phase, 1);
        chk("start_fstart", freq_start, 1);
        chk("start_freq", freq, 35000);

        // Normal search: freq tracks new_freq one edge later
        for (int i = 0; i < 4; i++) begin
            new_freq = 20'(30000 + 100 * i);
            tick();
            chk("track_freq", freq, 32'(30000 + 100 * i));
            chk("track_fstart", freq_start, 0);
        end
        new_freq = 20'd30400; freq_alg_done = 1'b1; best_freq = 20'd30200;
        tick();
        freq_alg_done = 1'b0;
        chk("done_freq", freq, 30200);
        chk("done_phase", phase, 2);
        chk("meas_first", measure, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("meas_high", measure, 1);
            chk("meas_nodone", meas_done, 0);
        end
        tick();
        chk("data_phase", phase, 3);
        chk("data_measure", measure, 0);
        chk("data_mdone", meas_done, 1);
        tick();
        chk("mdone_once", meas_done, 0);

        // Measurement requests in DATA are registered
        data_meas_req = 1'b1;
        tick();
        chk("dreq_hi", measure, 1);
        data_meas_req = 1'b0;
        tick();
        chk("dreq_lo", measure, 0);

        // On-demand re-optimisation
        reopt_req = 1'b1;
        tick();
        reopt_req = 1'b0;
        chk("reopt_phase", phase, 1);
        chk("reopt_fstart", freq_start, 1);

        // Timeout: 16 cycles in FREQ_OPT
        new_freq = 20'd31000;
        tick(15);
        chk("to_pre_phase", phase, 1);
        chk("to_pre_flag", opt_timeout, 0);
        chk("to_pre_freq", freq, 31000);
        tick();
        chk("to_phase", phase, 2);
        chk("to_freq", freq, 35000);
        chk("to_flag", opt_timeout, 1);

        // Heartbeat loss on the 4th MEASURE cycle
        tick(3);
        chk("hb_pre_measure", measure, 1);
        swipt_alive = 1'b0;
        tick();
        chk("hb_measure", measure, 0);
        chk("hb_mdone", meas_done, 0);
        chk("hb_phase", phase, 0);
        chk("hb_freq", freq, 35000);
        chk("hb_flag", opt_timeout, 1);
        tick();
        chk("hb_mdone2", meas_done, 0);
        swipt_alive = 1'b1;
        tick();
        chk("hb_restart", freq_start, 1);

        // Successful search clears the timeout flag
        freq_alg_done = 1'b1; best_freq = 20'd40000;
        tick();
        freq_alg_done = 1'b0;
        chk("clr_flag", opt_timeout, 0);
        chk("clr_freq", freq, 40000);
        tick(8);
        chk("clr_data", phase, 3);

        // Comms override with range check
        comms_ctrl = 1'b1; comms_valid = 1'b1; comms_freq = 20'd50000; comms_duty = 12'd300;
        tick();
        chk("cm_phase", phase, 4);
        chk("cm_freq", freq, 50000);
        chk("cm_duty", duty, 300);
        chk("cm_noerr", comms_err, 0);
        comms_freq = 20'd150000; comms_duty = 12'd100;
        tick();
        chk("cm_rej_err", comms_err, 1);
        chk("cm_rej_freq", freq, 50000);
        chk("cm_rej_duty", duty, 300);
        comms_valid = 1'b0;
        tick();
        chk("cm_err_pulse", comms_err, 0);
        comms_valid = 1'b1; comms_freq = 20'd20000; comms_duty = 12'd111;
        tick();
        chk("cm_min_freq", freq, 20000);
        chk("cm_min_err", comms_err, 0);
        comms_freq = 20'd100001; comms_duty = 12'd5;
        tick();
        chk("cm_over_err", comms_err, 1);
        chk("cm_over_duty", duty, 111);
        comms_freq = 20'd100000; comms_duty = 12'd7;
        tick();
        chk("cm_max_freq", freq, 100000);
        chk("cm_max_duty", duty, 7);
        comms_valid = 1'b0; comms_ctrl = 1'b0;
        tick();
        chk("cm_drop_phase", phase, 0);
        chk("cm_drop_freq", freq, 100000);
        tick();
        chk("cm_reopt_phase", phase, 1);
        chk("cm_reopt_fstart", freq_start, 1);
        chk("cm_keep_duty", duty, 7);

        // Comms rising mid-search abandons it without a timeout flag
        comms_ctrl = 1'b1;
        tick();
        chk("cmid_phase", phase, 4);
        chk("cmid_flag", opt_timeout, 0);
        chk("cmid_fstart", freq_start, 0);
        comms_ctrl = 1'b0;
        tick(2);
        chk("cmid_restart", freq_start, 1);

        // Automatic re-optimisation after 20 DATA cycles (second instance)
        swipt_alive2 = 1'b1;
        tick();
        chk("ar_start", phase2, 1);
        freq_alg_done = 1'b1; best_freq = 20'd33000;
        tick();
        freq_alg_done = 1'b0;
        chk("ar_freq", freq2, 33000);
        tick(8);
        chk("ar_data", phase2, 3);
        chk("ar_mdone", meas_done2, 1);
        tick(19);
        chk("ar_still_data", phase2, 3);
        chk("ar_no_fstart", freq_start2, 0);
        tick();
        chk("ar_phase", phase2, 1);
        chk("ar_fstart", freq_start2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
